// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Arbitrates two requesters (processor and program-loader/debug port) onto a
// single unified memory port. One access is in flight at a time. The FSM
// latches the winning request, holds the memory request stable until memAck
// or a wait timeout, then pulses the winner's Ready for one cycle.
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN  - when defined, simultaneous requests alternate between
//                         the two ports using a last-grant register. When it is
//                         undefined, the CPU has fixed priority and no last-grant
//                         register exists.
//
// Parameters:
//   ADDR_W   address bus width
//   DATA_W   data bus width
//   TIMEOUT  maximum BUSY cycles spent waiting for memAck (>= 1)
//
// Ports:
//   clock, resetN              clock, synchronous active-low reset
//   cpuReq/cpuWrite/cpuAddr/cpuWData      processor request (level) and fields
//   cpuRData/cpuReady                     processor read data, completion pulse
//   loadReq/loadWrite/loadAddr/loadWData  loader request (level) and fields
//   loadRData/loadReady                   loader read data, completion pulse
//   memEn/memWe/memAddr/memWData          shared memory request (registered)
//   memRData/memAck                       memory read data, completion strobe
//   busy                                  high whenever the FSM is not IDLE
//   accessErr                             pulse with Ready when the access timed out
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              resetN,

  input  logic              cpuReq,
  input  logic              cpuWrite,
  input  logic [ADDR_W-1:0] cpuAddr,
  input  logic [DATA_W-1:0] cpuWData,
  output logic [DATA_W-1:0] cpuRData,
  output logic              cpuReady,

  input  logic              loadReq,
  input  logic              loadWrite,
  input  logic [ADDR_W-1:0] loadAddr,
  input  logic [DATA_W-1:0] loadWData,
  output logic [DATA_W-1:0] loadRData,
  output logic              loadReady,

  output logic              memEn,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  input  logic [DATA_W-1:0] memRData,
  input  logic              memAck,

  output logic              busy,
  output logic              accessErr
);

  // state | meaning
  // IDLE  | no access in flight; sample requests and latch the winner
  // BUSY  | memory request held on memEn/memWe/memAddr/memWData, waiting for memAck
  // DONE  | winner's Ready (and accessErr on timeout) high for this one cycle
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT);

  state_t            state, stateNext;
  logic              grantLoad, grantLoadNext;
  logic [CNT_W-1:0]  waitCnt, waitCntNext;

  logic              memEnNext, memWeNext;
  logic [ADDR_W-1:0] memAddrNext;
  logic [DATA_W-1:0] memWDataNext;
  logic [DATA_W-1:0] cpuRDataNext, loadRDataNext;
  logic              cpuReadyNext, loadReadyNext, accessErrNext;

  logic              anyReq;
  logic              pickLoad;

  assign anyReq = cpuReq | loadReq;

`ifdef ARB_ROUND_ROBIN_EN
  // lastLoad=1 means the loader won the most recent grant; reset favours the CPU
  // on the first contended request.
  logic lastLoad;

  assign pickLoad = loadReq & (~cpuReq | ~lastLoad);

  always_ff @(posedge clock) begin
    if (!resetN) begin
      lastLoad <= 1'b1;
    end else if (state == IDLE && anyReq) begin
      lastLoad <= pickLoad;
    end
  end
`else
  assign pickLoad = loadReq & ~cpuReq;
`endif

  assign busy = (state != IDLE);

  always_comb begin
    stateNext     = state;
    grantLoadNext = grantLoad;
    waitCntNext   = waitCnt;
    memEnNext     = memEn;
    memWeNext     = memWe;
    memAddrNext   = memAddr;
    memWDataNext  = memWData;
    cpuRDataNext  = cpuRData;
    loadRDataNext = loadRData;
    cpuReadyNext  = 1'b0;
    loadReadyNext = 1'b0;
    accessErrNext = 1'b0;

    case (state)
      IDLE: begin
        if (anyReq) begin
          stateNext     = BUSY;
          grantLoadNext = pickLoad;
          waitCntNext   = '0;
          memEnNext     = 1'b1;
          memWeNext     = pickLoad ? loadWrite : cpuWrite;
          memAddrNext   = pickLoad ? loadAddr  : cpuAddr;
          memWDataNext  = pickLoad ? loadWData : cpuWData;
        end
      end

      BUSY: begin
        // memAck wins over the timeout when both land in the same cycle.
        if (memAck) begin
          stateNext     = DONE;
          memEnNext     = 1'b0;
          cpuReadyNext  = ~grantLoad;
          loadReadyNext = grantLoad;
          if (!memWe) begin
            if (grantLoad) begin
              loadRDataNext = memRData;
            end else begin
              cpuRDataNext = memRData;
            end
          end
        end else if (waitCnt == LAST_WAIT) begin
          // This cycle's increment brings the counter to TIMEOUT: give up.
          stateNext     = DONE;
          waitCntNext   = WAIT_LIMIT;
          memEnNext     = 1'b0;
          cpuReadyNext  = ~grantLoad;
          loadReadyNext = grantLoad;
          accessErrNext = 1'b1;
        end else begin
          waitCntNext = waitCnt + CNT_W'(1);
        end
      end

      DONE: begin
        stateNext = IDLE;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Ready/accessErr are registered on the BUSY->DONE edge so they are high
  // exactly during DONE and drop on the return to IDLE.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      state     <= IDLE;
      grantLoad <= 1'b0;
      waitCnt   <= '0;
      memEn     <= 1'b0;
      memWe     <= 1'b0;
      memAddr   <= '0;
      memWData  <= '0;
      cpuRData  <= '0;
      loadRData <= '0;
      cpuReady  <= 1'b0;
      loadReady <= 1'b0;
      accessErr <= 1'b0;
    end else begin
      state     <= stateNext;
      grantLoad <= grantLoadNext;
      waitCnt   <= waitCntNext;
      memEn     <= memEnNext;
      memWe     <= memWeNext;
      memAddr   <= memAddrNext;
      memWData  <= memWDataNext;
      cpuRData  <= cpuRDataNext;
      loadRData <= loadRDataNext;
      cpuReady  <= cpuReadyNext;
      loadReady <= loadReadyNext;
      accessErr <= accessErrNext;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed and randomized accesses against mem_port_arbiter. The bench plays
// both requesters and the memory. Expected results come from a transaction-
// level model: who wins, how many BUSY cycles the access lasts
// (ack cycle, or TIMEOUT if no ack), whether it errors, and what each port's
// read-data register should hold.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;

  logic              clock = 1'b0;
  logic              resetN;
  logic              cpuReq, cpuWrite;
  logic [ADDR_W-1:0] cpuAddr;
  logic [DATA_W-1:0] cpuWData, cpuRData;
  logic              cpuReady;
  logic              loadReq, loadWrite;
  logic [ADDR_W-1:0] loadAddr;
  logic [DATA_W-1:0] loadWData, loadRData;
  logic              loadReady;
  logic              memEn, memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWData, memRData;
  logic              memAck;
  logic              busy, accessErr;

  int checks = 0;
  int errors = 0;

  // transaction-level model state
  logic [DATA_W-1:0] cpuRModel, loadRModel;
  logic              lastLoadModel;

  // outstanding requests per port
  logic              cpuPend, cpuPW, loadPend, loadPW;
  logic [ADDR_W-1:0] cpuPA, loadPA;
  logic [DATA_W-1:0] cpuPD, loadPD;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .resetN(resetN),
    .cpuReq(cpuReq), .cpuWrite(cpuWrite), .cpuAddr(cpuAddr), .cpuWData(cpuWData),
    .cpuRData(cpuRData), .cpuReady(cpuReady),
    .loadReq(loadReq), .loadWrite(loadWrite), .loadAddr(loadAddr), .loadWData(loadWData),
    .loadRData(loadRData), .loadReady(loadReady),
    .memEn(memEn), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
    .memRData(memRData), .memAck(memAck),
    .busy(busy), .accessErr(accessErr)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drivePending();
    cpuReq    = cpuPend;
    cpuWrite  = cpuPW;
    cpuAddr   = cpuPA;
    cpuWData  = cpuPD;
    loadReq   = loadPend;
    loadWrite = loadPW;
    loadAddr  = loadPA;
    loadWData = loadPD;
  endtask

  task automatic scramble();
    cpuReq    = 1'($urandom);
    cpuWrite  = 1'($urandom);
    cpuAddr   = $urandom;
    cpuWData  = $urandom;
    loadReq   = 1'($urandom);
    loadWrite = 1'($urandom);
    loadAddr  = $urandom;
    loadWData = $urandom;
  endtask

  // Runs one access starting at a negedge with the DUT in IDLE.
  // ackCycle: BUSY cycle (1-based) in which memAck is driven; 0 = never.
  task automatic doAccess(input int ackCycle, input logic [DATA_W-1:0] rd);
    logic              winLoad, expWe, expErr;
    logic [ADDR_W-1:0] expAddr;
    logic [DATA_W-1:0] expWData;
    int                expBusy, nb;

    drivePending();
    memAck   = 1'b0;
    memRData = $urandom;
    check1("idle_busy", busy, 1'b0);

`ifdef ARB_ROUND_ROBIN_EN
    winLoad = loadPend && (!cpuPend || !lastLoadModel);
`else
    winLoad = loadPend && !cpuPend;
`endif
    lastLoadModel = winLoad;
    expWe    = winLoad ? loadPW : cpuPW;
    expAddr  = winLoad ? loadPA : cpuPA;
    expWData = winLoad ? loadPD : cpuPD;
    expErr   = !(ackCycle >= 1 && ackCycle <= TIMEOUT);
    expBusy  = expErr ? TIMEOUT : ackCycle;

    @(negedge clock);
    nb = 0;
    while (cpuReady !== 1'b1 && loadReady !== 1'b1 && nb < TIMEOUT + 4) begin
      nb++;
      check1("busy_memEn", memEn, 1'b1);
      check1("busy_busy", busy, 1'b1);
      check1("busy_memWe", memWe, expWe);
      check32("busy_memAddr", memAddr, expAddr);
      check32("busy_memWData", memWData, expWData);
      memAck   = (nb == ackCycle);
      memRData = (nb == ackCycle) ? rd : $urandom;
      scramble();
      @(negedge clock);
    end
    check32("busy_cycles", 32'(nb), 32'(expBusy));

    if (!expErr && !expWe) begin
      if (winLoad) loadRModel = rd;
      else         cpuRModel  = rd;
    end
    check1("done_cpuReady", cpuReady, !winLoad);
    check1("done_loadReady", loadReady, winLoad);
    check1("done_accessErr", accessErr, expErr);
    check1("done_memEn", memEn, 1'b0);
    check1("done_busy", busy, 1'b1);
    check32("done_cpuRData", cpuRData, cpuRModel);
    check32("done_loadRData", loadRData, loadRModel);

    if (winLoad) loadPend = 1'b0;
    else         cpuPend  = 1'b0;
    drivePending();
    memAck   = 1'($urandom);
    memRData = $urandom;
    @(negedge clock);
    check1("idle_cpuReady", cpuReady, 1'b0);
    check1("idle_loadReady", loadReady, 1'b0);
    check1("idle_accessErr", accessErr, 1'b0);
    check1("idle_memEn", memEn, 1'b0);
    check1("idle_busy_after", busy, 1'b0);
    check32("idle_cpuRData", cpuRData, cpuRModel);
    check32("idle_loadRData", loadRData, loadRModel);

    if (!cpuPend && !loadPend) begin
      // a stray ack in IDLE must not start or complete anything
      memAck = 1'b1;
      @(negedge clock);
      check1("idleack_busy", busy, 1'b0);
      check1("idleack_cpuReady", cpuReady, 1'b0);
      check1("idleack_loadReady", loadReady, 1'b0);
      memAck = 1'b0;
    end
  endtask

  task automatic resetModel();
    cpuRModel     = '0;
    loadRModel    = '0;
    lastLoadModel = 1'b1;
    cpuPend       = 1'b0;
    loadPend      = 1'b0;
  endtask

  task automatic setCpu(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    cpuPend = 1'b1; cpuPW = w; cpuPA = a; cpuPD = d;
  endtask

  task automatic setLoad(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    loadPend = 1'b1; loadPW = w; loadPA = a; loadPD = d;
  endtask

  initial begin
    int r, ack;

    resetN = 1'b0;
    cpuPW = 1'b0; cpuPA = '0; cpuPD = '0;
    loadPW = 1'b0; loadPA = '0; loadPD = '0;
    resetModel();
    drivePending();
    memAck   = 1'b0;
    memRData = '0;

    repeat (3) @(negedge clock);
    check1("rst_memEn", memEn, 1'b0);
    check1("rst_memWe", memWe, 1'b0);
    check32("rst_memAddr", memAddr, 32'h0);
    check32("rst_memWData", memWData, 32'h0);
    check32("rst_cpuRData", cpuRData, 32'h0);
    check32("rst_loadRData", loadRData, 32'h0);
    check1("rst_cpuReady", cpuReady, 1'b0);
    check1("rst_loadReady", loadReady, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_accessErr", accessErr, 1'b0);
    resetN = 1'b1;
    @(negedge clock);

    // CPU read, ack in first BUSY cycle
    setCpu(1'b0, 32'h40, 32'h0);
    doAccess(1, 32'hDEADBEEF);
    check32("cpu_read_data", cpuRData, 32'hDEADBEEF);

    // loader write, ack in third BUSY cycle
    setLoad(1'b1, 32'h100, 32'h12345678);
    doAccess(3, 32'hCAFEF00D);
    check32("load_write_rdata", loadRData, 32'h0);

    // simultaneous requests, both held until served
    setCpu(1'b0, 32'h200, 32'h0);
    setLoad(1'b0, 32'h300, 32'h0);
    doAccess(1, 32'hA5A5A5A5);
    doAccess(2, 32'h5A5A5A5A);

    // timeout: never acked, cpuRData keeps its old value
    setCpu(1'b0, 32'h44, 32'h0);
    doAccess(0, 32'h0BADF00D);

    // ack on the very cycle the counter would reach TIMEOUT is a success
    setCpu(1'b0, 32'h48, 32'h0);
    doAccess(TIMEOUT, 32'h13579BDF);
    check32("edge_ack_data", cpuRData, 32'h13579BDF);

    // reset in the second BUSY cycle of a CPU read
    setCpu(1'b0, 32'h80, 32'h0);
    drivePending();
    memAck = 1'b0;
    @(negedge clock);
    check1("rstbusy_memEn1", memEn, 1'b1);
    @(negedge clock);
    check1("rstbusy_memEn2", memEn, 1'b1);
    resetN = 1'b1 ^ 1'b1;
    resetModel();
    drivePending();
    @(negedge clock);
    check1("rstbusy_memEn_after", memEn, 1'b0);
    check1("rstbusy_cpuReady", cpuReady, 1'b0);
    check1("rstbusy_busy", busy, 1'b0);
    check32("rstbusy_cpuRData", cpuRData, 32'h0);
    resetN = 1'b1;
    @(negedge clock);
    check1("rstbusy_noReady", cpuReady, 1'b0);
    setCpu(1'b0, 32'h84, 32'h0);
    doAccess(2, 32'h2468ACE0);

    // randomized traffic
    for (int i = 0; i < 80; i++) begin
      if (!cpuPend && $urandom_range(0, 1) == 1)
        setCpu(1'($urandom), $urandom, $urandom);
      if (!loadPend && $urandom_range(0, 1) == 1)
        setLoad(1'($urandom), $urandom, $urandom);
      if (!cpuPend && !loadPend)
        setCpu(1'($urandom), $urandom, $urandom);
      r = $urandom_range(0, 9);
      if (r < 6)      ack = $urandom_range(1, 4);
      else if (r < 8) ack = $urandom_range(5, TIMEOUT);
      else            ack = 0;
      doAccess(ack, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, width of the address buses.
REQ-002 Parameter: DATA_W, default 32, width of the data buses.
REQ-003 Parameter: TIMEOUT, default 15, maximum BUSY cycles spent waiting for memAck.
REQ-004 Port: clock, input, 1, single clock; all state updates on the rising edge.
REQ-005 Port: resetN, input, 1, synchronous active-low reset sampled on the clock rising edge.
REQ-006 Port: cpuReq, cpuWrite, input, 1 each, processor access request (level) and write select; sourced from the control unit's memRead/memWrite.
REQ-007 Port: cpuAddr, input, ADDR_W; cpuWData, input, DATA_W; processor address and write data, selected upstream by IorD.
REQ-008 Port: cpuRData, output, DATA_W; cpuReady, output, 1; processor read data and one-cycle completion pulse.
REQ-009 Port: loadReq, loadWrite, input, 1 each; loadAddr, input, ADDR_W; loadWData, input, DATA_W; program-loader/debug port request.
REQ-010 Port: loadRData, output, DATA_W; loadReady, output, 1; loader read data and completion pulse.
REQ-011 Port: memEn, memWe, output, 1 each; memAddr, output, ADDR_W; memWData, output, DATA_W; shared unified memory request.
REQ-012 Port: memRData, input, DATA_W; memAck, input, 1; memory read data and completion strobe.
REQ-013 Port: busy, output, 1, high in any state other than IDLE; used as a processor stall.
REQ-014 Port: accessErr, output, 1, one-cycle pulse, coincident with Ready, when the access timed out.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-016 IDLE with at least one req high: latch the winner's grant, Write, Addr and WData into memWe/memAddr/memWData; set memEn=1; go to BUSY.
REQ-017 Without ARB_ROUND_ROBIN_EN, simultaneous cpuReq and loadReq SHALL grant the CPU.
REQ-018 BUSY: memEn, memWe, memAddr and memWData SHALL be held constant.
REQ-019 BUSY with memAck=1: capture memRData into the granted RData register (reads only); set memEn=0; go to DONE.
REQ-020 BUSY: a wait counter SHALL increment each cycle without memAck.
REQ-021 BUSY: when the wait counter reaches TIMEOUT, set memEn=0, flag the error and go to DONE; RData SHALL be left unchanged.
REQ-022 BUSY: memAck arriving in the same cycle the counter reaches TIMEOUT SHALL be treated as success.
REQ-023 DONE: pulse the granted requester's Ready for exactly one cycle (with accessErr if flagged); go to IDLE.
REQ-024 Minimum access latency SHALL be 3 cycles from the req sample in IDLE to the Ready pulse, with memAck in the first BUSY cycle.
REQ-025 A requester SHALL deassert req on the cycle after sampling Ready; a req still high in IDLE is a new request.
REQ-026 Any req or field change of the non-granted or granted requester during BUSY/DONE SHALL be ignored.
REQ-027 memAck sampled in IDLE or DONE SHALL be ignored.
REQ-028 cpuRData/loadRData SHALL hold their last captured value until the next successful read on that port.
REQ-029 Write accesses SHALL NOT modify RData.

Reset
REQ-030 While resetN=0 at a rising edge, the block SHALL enter IDLE.
REQ-031 Reset values: memEn=0, memWe=0, memAddr=0, memWData=0, cpuRData=0, loadRData=0, cpuReady=0, loadReady=0, busy=0, accessErr=0, wait counter=0, last-grant=loader.
REQ-032 Reset during BUSY or DONE SHALL abort the access with no Ready pulse; memEn SHALL be 0 from the first cycle after the reset edge.

Configuration
REQ-033 Macro ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-034 With ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL go to the requester not granted last; a lone request is always granted.
REQ-035 With ARB_ROUND_ROBIN_EN defined, last-grant SHALL update at every IDLE->BUSY transition.
REQ-036 Without ARB_ROUND_ROBIN_EN, fixed CPU priority SHALL apply and the last-grant register SHALL be absent.

Verification
REQ-037 CPU read, addr 0x40, memAck 1 cycle after memEn, memRData 0xDEADBEEF -> cpuRData=0xDEADBEEF, one cpuReady pulse, 3-cycle latency, loadReady stays 0.
REQ-038 Loader write, addr 0x100, data 0x12345678 -> memWe=1, memAddr=0x100, memWData=0x12345678 held until memAck; loadReady pulses; loadRData unchanged.
REQ-039 cpuReq and loadReq raised in the same cycle, held -> default build: CPU then loader; ARB_ROUND_ROBIN_EN build after a prior CPU grant: loader first.
REQ-040 memAck never asserted, TIMEOUT=15 -> memEn drops after 15 BUSY cycles; cpuReady and accessErr pulse together; cpuRData keeps its old value.
REQ-041 resetN=0 asserted in the second BUSY cycle of a CPU read -> memEn=0 next cycle, no cpuReady; state IDLE; a new request completes normally.
